// File: rtl/aiapa_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : aiapa_pkg
//  Description : Shared annealer definitions: default problem size, coupling
//                word width, energy-width helper and the energy-sequencer FSM
//                state type (also observed by top_controller for debug).
//  Revision    : 1.0 - initial release
// ============================================================================
package aiapa_pkg;

    localparam int c_spins = 800;  // default spin count / coupling rows
    localparam int c_jw    = 4;    // default bits per coupling (sign + magnitude)

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_SNAP = 3'd1,
        ST_RD   = 3'd2,
        ST_ACC  = 3'd3,
        ST_DONE = 3'd4
    } seq_state_t;

    // Smallest signed width that holds +/- n(n-1)/2 * (2^(jw-1)-1).
    function automatic int energy_width(input int n, input int jw);
        longint max_e;
        max_e = (longint'(n) * longint'(n - 1) / 2) * ((longint'(1) << (jw - 1)) - 1);
        energy_width = 64;
        for (int w = 63; w >= 1; w--) begin
            if (((longint'(1) << (w - 1)) - 1) >= max_e) begin
                energy_width = w;
            end
        end
    endfunction

endpackage
`default_nettype wire

// File: rtl/coupling_chunk_sum.sv
`default_nettype none
// ============================================================================
//  Module      : coupling_chunk_sum
//  Description : Combinational P-lane Ising contribution sum. Each live lane
//                adds +m when (row spin == partner spin) equals the coupling
//                sign bit, otherwise -m. Masked lanes add 0. Lanes are reduced
//                through a balanced adder tree.
//  Ports       : couplings     in  P*JW  lane c at [c*JW +: JW], MSB = sign
//                partner_spins in  P     spin of coupling partner per lane
//                row_spin      in  1     spin of the current row
//                lane_mask     in  P     1 = lane carries a real coupling
//                sum           out SW    signed chunk sum
//  Revision    : 1.0 - initial release
// ============================================================================
module coupling_chunk_sum #(
    parameter int P  = 16,
    parameter int JW = 4,
    parameter int SW = JW + $clog2(P)
) (
    input  logic [P*JW-1:0]      couplings,
    input  logic [P-1:0]         partner_spins,
    input  logic                 row_spin,
    input  logic [P-1:0]         lane_mask,
    output logic signed [SW-1:0] sum
);

    localparam int c_lv = (P > 1) ? $clog2(P) : 0;
    localparam int c_pp = 1 << c_lv;  // lanes padded to a power of two

    generate
        for (genvar l = 0; l <= c_lv; l++) begin : g_lvl
            logic signed [SW-1:0] w_s [c_pp >> l];
            if (l == 0) begin : g_leaf
                for (genvar c = 0; c < c_pp; c++) begin : g_lane
                    if (c < P) begin : g_live
                        assign w_s[c] = !lane_mask[c] ? '0 :
                            (((row_spin == partner_spins[c]) == couplings[c*JW + JW-1]) ?
                                SW'({1'b0, couplings[c*JW +: JW-1]}) :
                               -SW'({1'b0, couplings[c*JW +: JW-1]}));
                    end else begin : g_pad
                        assign w_s[c] = '0;
                    end
                end
            end else begin : g_add
                for (genvar i = 0; i < (c_pp >> l); i++) begin : g_pair
                    assign w_s[i] = g_lvl[l-1].w_s[2*i] + g_lvl[l-1].w_s[2*i+1];
                end
            end
        end
    endgenerate

    assign sum = g_lvl[c_lv].w_s[0];

endmodule
`default_nettype wire

// File: rtl/ising_energy_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : ising_energy_sequencer
//  Description : Snapshots the spin vector, walks the lower triangle of the
//                coupling memory (rows 1..N-1, P couplings per cycle) and
//                accumulates the signed Ising energy. Tracks the minimum
//                energy and the sweep index where it occurred.
//  Ports       : clk, rst_n          clock / async active-low reset
//                start, sweep_k      run request and its sweep index
//                clr_best            clear best tracker (idle only)
//                spins               live spin vector (bit s = spin s+1)
//                j_rd_en, j_addr     coupling row read; j_rdata 1 cycle later
//                busy, done          run in progress / one-cycle completion
//                energy              energy of last completed run
//                best_energy/best_k  minimum energy and its sweep index
//                best_valid          best tracker holds a result
//  Revision    : 1.0 - initial release
// ============================================================================
module ising_energy_sequencer
    import aiapa_pkg::*;
#(
    parameter int N  = c_spins,
    parameter int JW = c_jw,
    parameter int P  = 16,
    parameter int KW = 16,
    parameter int EW = 24
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [KW-1:0]         sweep_k,
    input  logic                  clr_best,
    input  logic [N-1:0]          spins,
    output logic                  j_rd_en,
    output logic [$clog2(N)-1:0]  j_addr,
    input  logic [N*JW-1:0]       j_rdata,
    output logic                  busy,
    output logic                  done,
    output logic [EW-1:0]         energy,
    output logic [EW-1:0]         best_energy,
    output logic [KW-1:0]         best_k,
    output logic                  best_valid
);

    localparam int                   c_aw   = $clog2(N);
    localparam int                   c_cw   = JW + $clog2(P);
    localparam logic signed [EW-1:0] c_emax = {1'b0, {(EW-1){1'b1}}};

    seq_state_t              r_state, w_state_nx;
    logic [N-1:0]            r_snap;
    logic [N*JW-1:0]         r_row_buf;
    logic [c_aw-1:0]         r_row;
    logic [c_aw-1:0]         r_chunk;
    logic [KW-1:0]           r_k;
    logic [KW-1:0]           r_best_k;
    logic signed [EW-1:0]    r_acc;
    logic signed [EW-1:0]    r_energy;
    logic signed [EW-1:0]    r_best;
    logic                    r_best_valid;
    logic                    r_done;

    logic [N*JW-1:0]         w_row_data;
    logic [JW-1:0]           w_row_arr [N];
    logic [P*JW-1:0]         w_lane_j;
    logic [P-1:0]            w_partner;
    logic [P-1:0]            w_mask;
    logic [c_aw-1:0]         w_idx;
    int                      w_pos;
    logic                    w_last_chunk;
    logic                    w_last_row;
    logic signed [c_cw-1:0]  w_chunk_sum;

    // Row data arrives on the first ACC cycle; later chunks use the copy.
    assign w_row_data = (r_chunk == '0) ? j_rdata : r_row_buf;

    generate
        for (genvar g = 0; g < N; g++) begin : g_row_split
            assign w_row_arr[g] = w_row_data[g*JW +: JW];
        end
    endgenerate

    // Lane c of chunk q covers coupling j = q*P + c; only j < r is real.
    always_comb begin
        w_lane_j  = '0;
        w_partner = '0;
        w_mask    = '0;
        w_pos     = 0;
        w_idx     = '0;
        for (int c = 0; c < P; c++) begin
            w_pos = int'(r_chunk) * P + c;
            w_idx = c_aw'(w_pos);
            if (w_pos < int'(r_row)) begin
                w_mask[c]             = 1'b1;
                w_partner[c]          = r_snap[w_idx];
                w_lane_j[c*JW +: JW]  = w_row_arr[w_idx];
            end
        end
    end

    assign w_last_chunk = ((int'(r_chunk) + 1) * P) >= int'(r_row);
    assign w_last_row   = (r_row == c_aw'(N - 1));

    coupling_chunk_sum #(
        .P  (P),
        .JW (JW),
        .SW (c_cw)
    ) u_chunk_sum (
        .couplings     (w_lane_j),
        .partner_spins (w_partner),
        .row_spin      (r_snap[r_row]),
        .lane_mask     (w_mask),
        .sum           (w_chunk_sum)
    );

    // ------------------------------------------------------------------ FSM
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        j_rd_en    = 1'b0;
        j_addr     = '0;
        unique case (r_state)
            ST_IDLE: if (start) w_state_nx = ST_SNAP;
            ST_SNAP: w_state_nx = ST_RD;
            ST_RD: begin
                j_rd_en    = 1'b1;
                j_addr     = r_row;
                w_state_nx = ST_ACC;
            end
            ST_ACC: begin
                if (w_last_chunk) begin
                    w_state_nx = w_last_row ? ST_DONE : ST_RD;
                end
            end
            ST_DONE: w_state_nx = ST_IDLE;
            default: w_state_nx = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------- datapath
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_snap       <= '0;
            r_row_buf    <= '0;
            r_row        <= '0;
            r_chunk      <= '0;
            r_k          <= '0;
            r_best_k     <= '0;
            r_acc        <= '0;
            r_energy     <= '0;
            r_best       <= c_emax;
            r_best_valid <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_done <= (r_state == ST_DONE);
            case (r_state)
                ST_IDLE: begin
                    // A clear in the start cycle lands before the new run.
                    if (clr_best) begin
                        r_best       <= c_emax;
                        r_best_valid <= 1'b0;
                    end
                    if (start) begin
                        r_k <= sweep_k;
                    end
                end
                ST_SNAP: begin
                    r_snap  <= spins;
                    r_acc   <= '0;
                    r_row   <= c_aw'(1);  // row 0 has no couplings
                    r_chunk <= '0;
                end
                ST_ACC: begin
                    if (r_chunk == '0) begin
                        r_row_buf <= j_rdata;
                    end
                    r_acc <= r_acc + EW'(w_chunk_sum);
                    if (w_last_chunk) begin
                        r_chunk <= '0;
                        if (!w_last_row) begin
                            r_row <= r_row + c_aw'(1);
                        end
                    end else begin
                        r_chunk <= r_chunk + c_aw'(1);
                    end
                end
                ST_DONE: begin
                    r_energy <= r_acc;
                    // Strict compare: ties keep the earlier sweep index.
                    if (!r_best_valid || (r_acc < r_best)) begin
                        r_best       <= r_acc;
                        r_best_k     <= r_k;
                        r_best_valid <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy        = (r_state != ST_IDLE);
    assign done        = r_done;
    assign energy      = r_energy;
    assign best_energy = r_best;
    assign best_k      = r_best_k;
    assign best_valid  = r_best_valid;

endmodule
`default_nettype wire
